// File: rtl/instr_fetch_tx_pkg.sv
// Shared types and constants for the instruction-fetch transmitter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package instr_fetch_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    REQ,
    RTZ
  } state_e;

  localparam int INSTR_W   = 16;
  localparam int PAYLOAD_W = 14;

  localparam logic [1:0] TAG_SPACER = 2'b00;
  localparam logic [1:0] PH_A       = 2'b01;
  localparam logic [1:0] PH_B       = 2'b10;

  localparam logic [INSTR_W-1:0] SPACER_WORD = {TAG_SPACER, {PAYLOAD_W{1'b0}}};

  // Phase token alternates A <-> B after every completed return-to-zero.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return (ph == PH_A) ? PH_B : PH_A;
  endfunction

endpackage

// File: rtl/instr_fetch_tx_sync_ff.sv
// Multi-flop bit synchronizer for an asynchronous level input, clears to 0.
// Latency: STAGES clock cycles (at least 2 flops are always built).
// Backpressure: none; a plain level follower.
module instr_fetch_tx_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Fewer than two flops would not give metastability a full cycle to resolve.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift the raw input one stage deeper per clock.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // Synchronizer chain with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/instr_fetch_tx.sv
// Fetches 14-bit instructions from a sync ROM and sends them phase-tagged over a 4-phase ack handshake.
// Latency: data valid 2 cycles after FETCH entry; next word only after ack rises and returns to zero.
// Backpressure: waits indefinitely on ack (sticky timeout_err after TIMEOUT_CYC); redirects while busy are queued.
module instr_fetch_tx
  import instr_fetch_tx_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 pc_load,
  input  logic [ADDR_W-1:0]    pc_new,
  output logic                 rom_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [PAYLOAD_W-1:0] rom_data,
  output logic [INSTR_W-1:0]   data,
  output logic [1:0]           ph,
  input  logic                 ack_in,
  output logic                 busy,
  output logic [15:0]          words_sent,
  output logic                 timeout_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

  logic                ack_s;

  state_e              state_q,       state_d;
  logic [ADDR_W-1:0]   pc_q,          pc_d;
  logic [INSTR_W-1:0]  data_q,        data_d;
  logic [1:0]          ph_q,          ph_d;
  logic                rom_en_q,      rom_en_d;
  logic [15:0]         words_sent_q,  words_sent_d;
  logic                timeout_err_q, timeout_err_d;
  logic                pend_vld_q,    pend_vld_d;
  logic [ADDR_W-1:0]   pend_pc_q,     pend_pc_d;
  logic [CNT_W-1:0]    to_cnt_q,      to_cnt_d;
  logic                wait_tick;

  instr_fetch_tx_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ack_in),
    .q    (ack_s)
  );

  // Next-state, datapath and handshake bookkeeping; ack is only looked at in REQ/RTZ.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    data_d        = data_q;
    ph_d          = ph_q;
    rom_en_d      = 1'b0;
    words_sent_d  = words_sent_q;
    timeout_err_d = timeout_err_q;
    pend_vld_d    = pend_vld_q;
    pend_pc_d     = pend_pc_q;
    to_cnt_d      = to_cnt_q;
    wait_tick     = 1'b0;

    // A redirect that arrives mid-word is parked; the newest one wins.
    if (pc_load && (state_q != IDLE)) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = pc_new;
    end

    case (state_q)
      IDLE: begin
        if (pc_load) begin
          // Direct redirect supersedes any older parked target and blocks launch this cycle.
          pc_d       = pc_new;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          pc_d       = pend_pc_q;
          pend_vld_d = 1'b0;
        end else if (run && !ack_s) begin
          state_d  = FETCH;
          rom_en_d = 1'b1;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        data_d   = {ph_q, rom_data};
        state_d  = REQ;
        to_cnt_d = '0;
      end
      REQ: begin
        if (ack_s) begin
          data_d       = SPACER_WORD;
          pc_d         = pc_q + ADDR_W'(1);
          words_sent_d = words_sent_q + 16'd1;
          state_d      = RTZ;
          to_cnt_d     = '0;
        end else begin
          wait_tick = 1'b1;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          ph_d    = next_phase(ph_q);
          state_d = IDLE;
        end else begin
          wait_tick = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Waiting on the receiver: count cycles, saturate, and flag once the limit is hit.
    if (wait_tick) begin
      if (to_cnt_q != TO_LIMIT) begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
      end
      if (to_cnt_q >= (TO_LIMIT - CNT_W'(1))) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  // All state and outputs registered; reset drops the receiver to a spacer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= PC_RST;
      data_q        <= SPACER_WORD;
      ph_q          <= PH_A;
      rom_en_q      <= 1'b0;
      words_sent_q  <= 16'd0;
      timeout_err_q <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_pc_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      data_q        <= data_d;
      ph_q          <= ph_d;
      rom_en_q      <= rom_en_d;
      words_sent_q  <= words_sent_d;
      timeout_err_q <= timeout_err_d;
      pend_vld_q    <= pend_vld_d;
      pend_pc_q     <= pend_pc_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign rom_addr    = pc_q;
  assign data        = data_q;
  assign ph          = ph_q;
  assign words_sent  = words_sent_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_tx.sv
// Scoreboard bench for instr_fetch_tx: ROM model, ack responder, expected words queued at launch.
// Latency: n/a (testbench).
// Backpressure: responder delays ack by a configurable number of cycles.
module tb_instr_fetch_tx;

  localparam int AW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_new = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [13:0]   rom_data = '0;
  logic [15:0]   data;
  logic [1:0]    ph;
  logic          ack_in = 1'b0;
  logic          busy;
  logic [15:0]   words_sent;
  logic          timeout_err;

  logic [13:0]   rom [256];
  exp_t          sb_q [$];
  exp_t          mon_e;

  int            checks = 0;
  int            failures = 0;

  logic [AW-1:0] m_pc;
  logic [1:0]    m_ph;
  logic [15:0]   m_ws;

  int            rom_en_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic          prev_vld = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_tx #(
    .ADDR_W     (AW),
    .RESET_PC   (0),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .data       (data),
    .ph         (ph),
    .ack_in     (ack_in),
    .busy       (busy),
    .words_sent (words_sent),
    .timeout_err(timeout_err)
  );

  // Synchronous ROM: data one cycle after the strobe.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: count ROM strobes, pop the scoreboard on each new valid word.
  always @(negedge clk) begin
    if (rom_en) begin
      rom_en_cnt++;
      last_addr = rom_addr;
    end
    if (rst_n && (data[15:14] == ph) && !prev_vld) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", data, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("word_addr", last_addr, mon_e.addr);
        check("word_data", data, mon_e.data);
        check("word_ph", ph, mon_e.data[15:14]);
        check("rom_en_per_word", rom_en_cnt, 1);
      end
      rom_en_cnt = 0;
    end
    prev_vld = rst_n && (data[15:14] == ph);
  end

  function automatic logic cond(input int what);
    case (what)
      0:       return data[15:14] == ph;
      1:       return data == 16'h0000;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int what, input string tag);
    int n;
    n = 0;
    while (!cond(what) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 60), 1);
  endtask

  task automatic push_exp();
    exp_t x;
    x.addr = m_pc;
    x.data = {m_ph, rom[m_pc]};
    sb_q.push_back(x);
  endtask

  // mode: 0 normal, 1 redirect during REQ, 2 ack withheld for timeout, 3 drop run during REQ
  task automatic send_word(input int mode, input logic [AW-1:0] redir);
    logic [15:0] held;
    held = {m_ph, rom[m_pc]};
    push_exp();
    wait_for(0, "req_seen");
    if (mode == 1) begin
      pc_load = 1'b1;
      pc_new  = redir;
      @(negedge clk);
      pc_load = 1'b0;
    end
    if (mode == 3) run = 1'b0;
    if (mode == 2) begin
      check("tmo_clear_at_req", timeout_err, 0);
      repeat (15) @(negedge clk);
      check("tmo_not_yet", timeout_err, 0);
      @(negedge clk);
      check("tmo_set", timeout_err, 1);
      repeat (10) @(negedge clk);
      check("tmo_data_held", data, held);
      check("tmo_sticky_wait", timeout_err, 1);
    end
    repeat (3) @(negedge clk);
    ack_in = 1'b1;
    wait_for(1, "spacer_seen");
    m_pc = m_pc + 8'd1;
    check("pc_after_ack", rom_addr, m_pc);
    repeat (3) @(negedge clk);
    ack_in = 1'b0;
    wait_for(2, "idle_seen");
    m_ph = (m_ph == 2'b01) ? 2'b10 : 2'b01;
    m_ws = m_ws + 16'd1;
    check("ph_after_rtz", ph, m_ph);
    check("words_sent", words_sent, m_ws);
    if (mode == 2) check("tmo_sticky_after", timeout_err, 1);
    if (mode == 1) m_pc = redir;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 14'(i * 14'h0155 + 14'h0A5A);
    rom[0] = 14'h1ABC;
    rom[1] = 14'h0123;
    m_pc = '0;
    m_ph = 2'b01;
    m_ws = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data, 16'h0000);
    check("rst_ph", ph, 2'b01);
    check("rst_rom_en", rom_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", rom_addr, 0);
    check("rst_words", words_sent, 0);
    check("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back words from pc 0, tags alternate
    run = 1'b1;
    for (int i = 0; i < 5; i++) send_word(0, '0);

    // Redirect during REQ of word at pc 5, then wrap from 8'hFF
    send_word(1, 8'h40);
    send_word(1, 8'hFF);
    send_word(0, '0);
    send_word(0, '0);

    // Ack withheld past the timeout limit
    send_word(2, '0);

    // run dropped mid-handshake: word finishes, no further fetch
    send_word(3, '0);
    repeat (20) @(negedge clk);
    check("norun_no_fetch", rom_en_cnt, 0);
    check("norun_idle", busy, 0);

    // Receiver still holding ack in IDLE: no launch until it releases
    ack_in = 1'b1;
    repeat (6) @(negedge clk);
    run = 1'b1;
    repeat (10) @(negedge clk);
    check("ackhi_no_launch", busy, 0);
    check("ackhi_no_fetch", rom_en_cnt, 0);
    ack_in = 1'b0;
    send_word(0, '0);

    // Asynchronous reset while in RTZ
    push_exp();
    wait_for(0, "rst_word_req");
    repeat (2) @(negedge clk);
    ack_in = 1'b1;
    wait_for(1, "rst_word_rtz");
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", data, 16'h0000);
    check("arst_ph", ph, 2'b01);
    check("arst_busy", busy, 0);
    check("arst_pc", rom_addr, 0);
    check("arst_tmo", timeout_err, 0);
    check("arst_words", words_sent, 0);
    ack_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_fetch", rom_en_cnt, 0);
    check("post_rst_idle", busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
